// File: rtl/mining_work_scheduler.sv
// mining_work_scheduler
//   Distributes accepted work (midstate + 96-bit header tail) to all mining
//   cores and collects their golden-ticket nonces. Each core owns a one-deep
//   hold register; a round-robin arbiter moves held nonces into a show-ahead
//   output FIFO. Tickets arriving shortly after a work change are discarded
//   as stale.
//
//   hash_clk, hash_rst_n          clock, asynchronous active-low reset
//   work_valid/work_ready         new-work handshake
//   work_midstate, work_data      work payload
//   core_midstate, core_data      work broadcast to every core
//   core_golden, core_nonce       per-core ticket pulse and nonce (core i at [32*i+31:32*i])
//   nonce_valid/nonce_ready       output FIFO handshake (head shown ahead)
//   nonce_out, nonce_core         FIFO head nonce and originating core
//   drop_count                    tickets lost to hold-register overrun, saturating at 255
module mining_work_scheduler #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALE_CYCLES = 256,
  localparam int unsigned ID_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      hash_clk,
  input  logic                      hash_rst_n,
  input  logic                      work_valid,
  output logic                      work_ready,
  input  logic [255:0]              work_midstate,
  input  logic [95:0]               work_data,
  output logic [255:0]              core_midstate,
  output logic [95:0]               core_data,
  input  logic [NUM_CORES-1:0]      core_golden,
  input  logic [32*NUM_CORES-1:0]   core_nonce,
  output logic                      nonce_valid,
  input  logic                      nonce_ready,
  output logic [31:0]               nonce_out,
  output logic [ID_W-1:0]           nonce_core,
  output logic [7:0]                drop_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned STALE_W = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;

  typedef logic [ID_W+31:0] entry_t;

  // Work path and stale window
  logic               work_accept;
  logic [STALE_W-1:0] stale_cnt;
  logic               stale;

  assign work_accept = work_valid && work_ready;
  assign stale       = (stale_cnt != '0);

  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      work_ready    <= 1'b0;
      core_midstate <= '0;
      core_data     <= '0;
      stale_cnt     <= '0;
    end else begin
      work_ready <= 1'b1;
      if (work_accept) begin
        core_midstate <= work_midstate;
        core_data     <= work_data;
        stale_cnt     <= STALE_W'(STALE_CYCLES);
      end else if (stale) begin
        stale_cnt <= stale_cnt - STALE_W'(1);
      end
    end
  end

  // Capture registers, arbiter and FIFO state
  logic [NUM_CORES-1:0] pending;
  logic [31:0]          hold [NUM_CORES];
  logic [ID_W-1:0]      rr_ptr;

  entry_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  entry_t               head;

  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;
  int unsigned          best_dist;
  logic [NUM_CORES-1:0] grant_vec;
  logic [NUM_CORES-1:0] capture_vec;
  logic [NUM_CORES-1:0] drop_vec;
  logic [8:0]           drop_sum;

  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Fullness is judged before any same-edge pop, so a full FIFO never
  // accepts a push even while it is being drained.
  // The pending core closest to rr_ptr (in wrap-around distance) wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_dist   = NUM_CORES;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (pending[i] && (((i + NUM_CORES - 32'(rr_ptr)) % NUM_CORES) < best_dist)) begin
          best_dist   = (i + NUM_CORES - 32'(rr_ptr)) % NUM_CORES;
          grant_valid = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  // A core granted this edge frees its hold register, so a ticket arriving
  // on the same edge is captured rather than dropped.
  always_comb begin
    grant_vec   = '0;
    capture_vec = '0;
    drop_vec    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      grant_vec[i]   = grant_valid && (32'(grant_idx) == i);
      capture_vec[i] = core_golden[i] && !stale && (!pending[i] || grant_vec[i]);
      drop_vec[i]    = core_golden[i] && !stale && pending[i] && !grant_vec[i];
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      drop_sum = drop_sum + 9'(drop_vec[i]);
    end
  end

  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      pending    <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (capture_vec[i]) begin
          hold[i]    <= core_nonce[32*i +: 32];
          pending[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        rr_ptr <= ID_W'((32'(grant_idx) + 1) % NUM_CORES);
      end
      drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  // Output FIFO
  assign push = grant_valid;
  assign pop  = (fifo_count != '0) && nonce_ready;

  always_ff @(posedge hash_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {grant_idx, hold[grant_idx]};
    end
  end

  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage is not reset; head fields read as zero while empty.
  assign head        = fifo_mem[rd_ptr];
  assign nonce_valid = (fifo_count != '0);
  assign nonce_out   = nonce_valid ? head[31:0] : '0;
  assign nonce_core  = nonce_valid ? head[ID_W+31:32] : '0;

endmodule

// File: tb/tb_mining_work_scheduler.sv
module tb_mining_work_scheduler;

  localparam int NC = 4;

  typedef logic [33:0] entry_t;

  logic          hash_clk;
  logic          hash_rst_n;
  logic          work_valid;
  logic          work_ready;
  logic [255:0]  work_midstate;
  logic [95:0]   work_data;
  logic [255:0]  core_midstate;
  logic [95:0]   core_data;
  logic [NC-1:0] core_golden;
  logic [127:0]  core_nonce;
  logic          nonce_valid;
  logic          nonce_ready;
  logic [31:0]   nonce_out;
  logic [1:0]    nonce_core;
  logic [7:0]    drop_count;

  int assertions = 0;
  int failures   = 0;
  entry_t sb[$];

  mining_work_scheduler #(
    .NUM_CORES(4),
    .FIFO_DEPTH(8),
    .STALE_CYCLES(4)
  ) dut (
    .hash_clk(hash_clk),
    .hash_rst_n(hash_rst_n),
    .work_valid(work_valid),
    .work_ready(work_ready),
    .work_midstate(work_midstate),
    .work_data(work_data),
    .core_midstate(core_midstate),
    .core_data(core_data),
    .core_golden(core_golden),
    .core_nonce(core_nonce),
    .nonce_valid(nonce_valid),
    .nonce_ready(nonce_ready),
    .nonce_out(nonce_out),
    .nonce_core(nonce_core),
    .drop_count(drop_count)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  // Scoreboard: every handshake seen on the output is checked against the
  // oldest expected entry.
  always @(negedge hash_clk) begin
    if (hash_rst_n && nonce_valid && nonce_ready) begin
      assertions++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got core %0d nonce %h, expected no output", nonce_core, nonce_out);
      end else begin
        entry_t exp;
        exp = sb.pop_front();
        if ({nonce_core, nonce_out} !== exp) begin
          failures++;
          $display("FAIL sb_order: got core %0d nonce %h, expected core %0d nonce %h",
                   nonce_core, nonce_out, exp[33:32], exp[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic wait_drain();
    nonce_ready = 1'b1;
    for (int i = 0; i < 60 && (nonce_valid || sb.size() != 0); i++) step();
  endtask

  task automatic set_pulse(input logic [NC-1:0] mask, input int core, input logic [31:0] val);
    core_golden = mask;
    core_nonce[32*core +: 32] = val;
  endtask

  task automatic test_reset();
    hash_rst_n = 1'b0;
    #12;
    assertions++; if (work_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b expected 0", work_ready); end
    assertions++; if (nonce_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", nonce_valid); end
    assertions++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    assertions++; if (core_midstate !== 256'd0) begin failures++; $display("FAIL reset_midstate: got %h expected 0", core_midstate); end
    hash_rst_n = 1'b1;
    #1;
    assertions++; if (work_ready !== 1'b0) begin failures++; $display("FAIL release_ready: got %0b expected 0", work_ready); end
    step();
    assertions++; if (work_ready !== 1'b1) begin failures++; $display("FAIL first_edge_ready: got %0b expected 1", work_ready); end
  endtask

  task automatic test_stale();
    work_midstate = {8{32'h0123_4567}};
    work_data     = {3{32'h89AB_CDEF}};
    work_valid    = 1'b1;
    step();
    work_valid = 1'b0;
    assertions++; if (core_midstate !== {8{32'h0123_4567}}) begin failures++; $display("FAIL work_midstate: got %h expected %h", core_midstate, {8{32'h0123_4567}}); end
    assertions++; if (core_data !== {3{32'h89AB_CDEF}}) begin failures++; $display("FAIL work_data: got %h expected %h", core_data, {3{32'h89AB_CDEF}}); end
    for (int e = 1; e <= 4; e++) begin
      set_pulse(4'b0001, 0, 32'h1000 + e);
      step();
      assertions++; if (nonce_valid !== 1'b0) begin failures++; $display("FAIL stale_ignored_%0d: got valid %0b expected 0", e, nonce_valid); end
    end
    set_pulse(4'b0001, 0, 32'hDEAD_BEEF);
    step();
    core_golden = '0;
    assertions++; if (nonce_valid !== 1'b0) begin failures++; $display("FAIL stale_latency_early: got valid %0b expected 0", nonce_valid); end
    step();
    assertions++; if (nonce_valid !== 1'b1) begin failures++; $display("FAIL stale_latency: got valid %0b expected 1", nonce_valid); end
    assertions++; if (nonce_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stale_nonce: got %h expected deadbeef", nonce_out); end
    assertions++; if (nonce_core !== 2'd0) begin failures++; $display("FAIL stale_core: got %0d expected 0", nonce_core); end
    assertions++; if (drop_count !== 8'd0) begin failures++; $display("FAIL stale_drop: got %0d expected 0", drop_count); end
    sb.push_back({2'd0, 32'hDEAD_BEEF});
    wait_drain();
    assertions++; if (nonce_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL stale_drain: got valid %0b left %0d expected 0 0", nonce_valid, sb.size()); end
  endtask

  task automatic test_reload();
    nonce_ready   = 1'b1;
    work_midstate = {8{32'hCAFE_F00D}};
    work_data     = {3{32'h5555_AAAA}};
    work_valid    = 1'b1;
    step();
    for (int e = 1; e <= 7; e++) begin
      work_valid = (e == 2);
      set_pulse(4'b0001, 0, 32'hA0 + e);
      step();
    end
    work_valid  = 1'b0;
    core_golden = '0;
    sb.push_back({2'd0, 32'hA7});
    assertions++; if (work_ready !== 1'b1) begin failures++; $display("FAIL reload_ready: got %0b expected 1", work_ready); end
    assertions++; if (core_data !== {3{32'h5555_AAAA}}) begin failures++; $display("FAIL reload_data: got %h expected %h", core_data, {3{32'h5555_AAAA}}); end
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_out !== 32'hA7) begin failures++; $display("FAIL reload_capture: got valid %0b nonce %h expected 1 a7", nonce_valid, nonce_out); end
    wait_drain();
    assertions++; if (nonce_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL reload_drain: got valid %0b left %0d expected 0 0", nonce_valid, sb.size()); end
  endtask

  task automatic test_round_robin();
    nonce_ready = 1'b1;
    set_pulse(4'b1000, 3, 32'h33);
    sb.push_back({2'd3, 32'h33});
    step();
    core_golden = '0;
    wait_drain();
    core_nonce[31:0]   = 32'hC0;
    core_nonce[95:64]  = 32'hC2;
    core_nonce[127:96] = 32'hC3;
    core_golden = 4'b1101;
    sb.push_back({2'd0, 32'hC0});
    sb.push_back({2'd2, 32'hC2});
    sb.push_back({2'd3, 32'hC3});
    step();
    core_golden = '0;
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_core !== 2'd0) begin failures++; $display("FAIL rr_first: got valid %0b core %0d expected 1 0", nonce_valid, nonce_core); end
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_core !== 2'd2) begin failures++; $display("FAIL rr_second: got valid %0b core %0d expected 1 2", nonce_valid, nonce_core); end
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_core !== 2'd3) begin failures++; $display("FAIL rr_third: got valid %0b core %0d expected 1 3", nonce_valid, nonce_core); end
    wait_drain();
    core_nonce[31:0]   = 32'hD0;
    core_nonce[127:96] = 32'hD3;
    core_golden = 4'b1001;
    sb.push_back({2'd0, 32'hD0});
    sb.push_back({2'd3, 32'hD3});
    step();
    core_golden = '0;
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_core !== 2'd0) begin failures++; $display("FAIL rr_pair_first: got valid %0b core %0d expected 1 0", nonce_valid, nonce_core); end
    wait_drain();
    assertions++; if (nonce_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL rr_drain: got valid %0b left %0d expected 0 0", nonce_valid, sb.size()); end
  endtask

  task automatic test_overrun_full_pop();
    nonce_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_pulse(4'b0001, 0, 32'h100 + i);
      sb.push_back({2'd0, 32'h100 + i});
      step();
    end
    core_golden = '0;
    step();
    set_pulse(4'b0010, 1, 32'h11);
    step();
    set_pulse(4'b0010, 1, 32'h22);
    step();
    core_golden = '0;
    assertions++; if (drop_count !== 8'd1) begin failures++; $display("FAIL overrun_drop: got %0d expected 1", drop_count); end
    step();
    step();
    assertions++; if (nonce_valid !== 1'b1 || nonce_out !== 32'h100 || nonce_core !== 2'd0) begin failures++; $display("FAIL overrun_head_stable: got valid %0b nonce %h core %0d expected 1 100 0", nonce_valid, nonce_out, nonce_core); end
    nonce_ready = 1'b1;
    step();
    nonce_ready = 1'b0;
    sb.push_back({2'd1, 32'h11});
    step();
    assertions++; if (drop_count !== 8'd1) begin failures++; $display("FAIL overrun_no_loss: got %0d expected 1", drop_count); end
    // Full again: a pop edge must not admit a push, so core 2's second ticket drops.
    set_pulse(4'b0100, 2, 32'h2A);
    step();
    nonce_ready = 1'b1;
    set_pulse(4'b0100, 2, 32'h2B);
    step();
    nonce_ready = 1'b0;
    core_golden = '0;
    assertions++; if (drop_count !== 8'd2) begin failures++; $display("FAIL fullpop_no_push: got drop %0d expected 2", drop_count); end
    sb.push_back({2'd2, 32'h2A});
    step();
    set_pulse(4'b1000, 3, 32'h3A);
    step();
    set_pulse(4'b1000, 3, 32'h3B);
    step();
    core_golden = '0;
    assertions++; if (drop_count !== 8'd3) begin failures++; $display("FAIL fullpop_refilled: got drop %0d expected 3", drop_count); end
    sb.push_back({2'd3, 32'h3A});
    wait_drain();
    assertions++; if (nonce_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL overrun_drain: got valid %0b left %0d expected 0 0", nonce_valid, sb.size()); end
  endtask

  task automatic test_saturation();
    nonce_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_pulse(4'b0001, 0, 32'h200 + i);
      sb.push_back({2'd0, 32'h200 + i});
      step();
    end
    core_golden = '0;
    step();
    set_pulse(4'b0010, 1, 32'h1F0);
    sb.push_back({2'd1, 32'h1F0});
    step();
    for (int n = 0; n < 300; n++) begin
      set_pulse(4'b0010, 1, 32'h300 + n);
      step();
      if (n == 99) begin
        assertions++; if (drop_count !== 8'd103) begin failures++; $display("FAIL sat_midway: got %0d expected 103", drop_count); end
      end
    end
    core_golden = '0;
    assertions++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_limit: got %0d expected 255", drop_count); end
    wait_drain();
    assertions++; if (nonce_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL sat_drain: got valid %0b left %0d expected 0 0", nonce_valid, sb.size()); end
  endtask

  task automatic test_reset_midop();
    nonce_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pulse(4'b0001, 0, 32'h400 + i);
      step();
    end
    core_golden = '0;
    step();
    set_pulse(4'b0010, 1, 32'h500);
    step();
    core_golden = '0;
    assertions++; if (nonce_valid !== 1'b1 || drop_count !== 8'd255) begin failures++; $display("FAIL midop_setup: got valid %0b drop %0d expected 1 255", nonce_valid, drop_count); end
    hash_rst_n = 1'b0;
    #1;
    assertions++; if (nonce_valid !== 1'b0) begin failures++; $display("FAIL midop_valid: got %0b expected 0", nonce_valid); end
    assertions++; if (drop_count !== 8'd0) begin failures++; $display("FAIL midop_drop: got %0d expected 0", drop_count); end
    assertions++; if (work_ready !== 1'b0 || core_midstate !== 256'd0) begin failures++; $display("FAIL midop_work: got ready %0b midstate %h expected 0 0", work_ready, core_midstate); end
    sb.delete();
    #2;
    hash_rst_n = 1'b1;
    step();
    assertions++; if (work_ready !== 1'b1) begin failures++; $display("FAIL midop_ready: got %0b expected 1", work_ready); end
    step();
    step();
    step();
    assertions++; if (nonce_valid !== 1'b0) begin failures++; $display("FAIL midop_empty: got valid %0b expected 0", nonce_valid); end
  endtask

  initial begin
    hash_rst_n    = 1'b0;
    work_valid    = 1'b0;
    work_midstate = '0;
    work_data     = '0;
    core_golden   = '0;
    core_nonce    = '0;
    nonce_ready   = 1'b0;
    test_reset();
    test_stale();
    test_reload();
    test_round_robin();
    test_overrun_full_pop();
    test_saturation();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
